// File: rtl/bp_pkg.sv
// Shared types and constants for the BytePipe transaction arbiter.
package bp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RSP   = 2'd3
   } bp_state_e;

   localparam int BP_WR_BIT = 7;

endpackage

// File: rtl/bp_rr_pick.sv
// Round-robin picker: first requester strictly above the last winner, wrapping.
module bp_rr_pick
   import bp_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int LW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [LW-1:0]    i_last,
   output logic [N_REQ-1:0] o_gnt
);

   logic found;
   int   k;

   always_comb begin
      o_gnt = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         k = (int'(i_last) + i) % N_REQ;
         if (!found && i_req[k]) begin
            o_gnt[k] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bp_txn_arb.sv
// Arbitrates N BytePipe requesters onto one target, one transaction per grant.
module bp_txn_arb
   import bp_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cg,
   input  logic [8*N_REQ-1:0] i_req_data,
   input  logic [N_REQ-1:0]   i_req_valid,
   output logic [N_REQ-1:0]   o_req_ready,
   output logic [7:0]         o_rsp_data,
   output logic [N_REQ-1:0]   o_rsp_valid,
   input  logic [N_REQ-1:0]   i_rsp_ready,
   output logic [7:0]         o_bp_data,
   output logic               o_bp_valid,
   input  logic               i_bp_ready,
   input  logic [7:0]         i_bp_data,
   input  logic               i_bp_valid,
   output logic               o_bp_ready,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_timeout
);

   localparam int LW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   bp_state_e        state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [LW-1:0]    last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             tmo_q, tmo_d;

   logic [N_REQ-1:0] pick;
   logic [LW-1:0]    gidx;
   logic [7:0]       gdata;
   logic             gvalid;
   logic             grdy;
   logic             fwd;
   logic             busy;
   logic             cmd_acc;
   logic             rsp_acc;

   bp_rr_pick #(
      .N_REQ (N_REQ),
      .LW    (LW)
   ) u_pick (
      .i_req  (i_req_valid),
      .i_last (last_q),
      .o_gnt  (pick)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) gidx = LW'(i);
      end
   end

   assign gdata  = i_req_data[8*int'(gidx) +: 8];
   assign gvalid = i_req_valid[gidx];
   assign grdy   = i_rsp_ready[gidx];

   assign fwd  = (state_q == ST_CMD) || (state_q == ST_WDATA);
   assign busy = fwd || (state_q == ST_RSP);

   // Target's input ready tracks the granted requester's reply ready.
   assign o_bp_data   = fwd ? gdata : 8'h00;
   assign o_bp_valid  = fwd && gvalid;
   assign o_req_ready = fwd ? (grant_q & {N_REQ{i_bp_ready}}) : '0;
   assign o_bp_ready  = busy && grdy;
   assign o_rsp_valid = busy ? (grant_q & {N_REQ{i_bp_valid}}) : '0;
   assign o_rsp_data  = i_bp_data;
   assign o_grant     = grant_q;
   assign o_timeout   = tmo_q;

   assign cmd_acc = o_bp_valid && i_bp_ready;
   assign rsp_acc = i_bp_valid && o_bp_ready;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      if (i_cg) begin
         tmo_d = 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (|i_req_valid) begin
                  grant_d = pick;
                  state_d = ST_CMD;
               end
            end
            ST_CMD: begin
               if (cmd_acc) begin
                  cnt_d   = '0;
                  state_d = gdata[BP_WR_BIT] ? ST_WDATA : ST_RSP;
               end
            end
            ST_WDATA: begin
               if (cmd_acc) begin
                  cnt_d   = '0;
                  state_d = ST_RSP;
               end
            end
            ST_RSP: begin
               // A reply on the last allowed cycle still wins over abort.
               if (rsp_acc || cnt_q == CW'(TIMEOUT)) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  last_d  = gidx;
                  tmo_d   = !rsp_acc;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= LW'(N_REQ - 1);
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule
